// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO of {pc, inst} between fetch and decode.
// Optional IFQ_PREDECODE_EN adds a stored control-flow flag per entry (deq_is_cf).
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_inst,
    input  logic                     flush,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_inst,
    output logic [$clog2(DEPTH):0]   count
`ifdef IFQ_PREDECODE_EN
    ,
    output logic                     deq_is_cf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] inst_mem_q [DEPTH];
`ifdef IFQ_PREDECODE_EN
    logic            cf_mem_q   [DEPTH];
`endif

    logic enq_fire;
    logic deq_fire;

    assign enq_ready = (count_q < FULL_CNT);
    assign deq_valid = (count_q != '0);
    assign count     = count_q;

    assign enq_fire = rdy && enq_valid && enq_ready && !flush;
    assign deq_fire = rdy && deq_valid && deq_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rdy) begin
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                // Power-of-two depth: pointers wrap by natural overflow.
                if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
                if (deq_fire) rd_ptr_d = rd_ptr_q + AW'(1);
                if (enq_fire && !deq_fire) count_d = count_q + CW'(1);
                else if (!enq_fire && deq_fire) count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; an emptied count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem_q[wr_ptr_q]   <= enq_pc;
            inst_mem_q[wr_ptr_q] <= enq_inst;
`ifdef IFQ_PREDECODE_EN
            cf_mem_q[wr_ptr_q]   <= (enq_inst[6:4] == 3'b110);
`endif
        end
    end

    assign deq_pc   = deq_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign deq_inst = deq_valid ? inst_mem_q[rd_ptr_q] : '0;
`ifdef IFQ_PREDECODE_EN
    assign deq_is_cf = deq_valid ? cf_mem_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries; power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32, width of the pc and instruction fields.
REQ-003 SHALL have input clk, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have input rdy, 1 bit: global ready; when low, all state holds.
REQ-006 SHALL have input enq_valid, 1 bit: fetch stage presents an instruction.
REQ-007 SHALL have output enq_ready, 1 bit: queue can accept an instruction.
REQ-008 SHALL have input enq_pc, XLEN bits: pc of the fetched instruction.
REQ-009 SHALL have input enq_inst, XLEN bits: fetched instruction word.
REQ-010 SHALL have input flush, 1 bit: branch/jump redirect; discards all entries.
REQ-011 SHALL have input deq_ready, 1 bit: decode stage consumes the head entry (not stalled).
REQ-012 SHALL have output deq_valid, 1 bit: head entry is valid.
REQ-013 SHALL have output deq_pc, XLEN bits: head pc; 0 when deq_valid is low.
REQ-014 SHALL have output deq_inst, XLEN bits: head instruction; 0 (bubble) when deq_valid is low.
REQ-015 SHALL have output count, log2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-016 SHALL accept an enqueue on a rising edge when rdy, enq_valid and enq_ready are all high and flush is low.
REQ-017 SHALL perform a dequeue on a rising edge when rdy, deq_valid and deq_ready are all high and flush is low.
REQ-018 SHALL drive enq_ready = (count < DEPTH), with no dependence on deq_ready; when full, an enqueue is refused even if a dequeue occurs in the same cycle.
REQ-019 SHALL drive deq_valid = (count != 0).
REQ-020 SHALL make an enqueued entry visible at the head no earlier than the cycle after it is written; there is no same-cycle bypass, so enqueue-to-dequeue latency is 1 cycle when empty.
REQ-021 SHALL, on a simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
REQ-023 SHALL preserve FIFO order.
REQ-024 SHALL, when flush is high with rdy high, set count and both pointers to 0 on that edge, ignoring any same-cycle enqueue or dequeue; deq_valid is low in the following cycle.
REQ-025 SHALL hold pointers, count and storage unchanged while rdy is low, including when flush is asserted.
REQ-026 SHALL derive deq_pc, deq_inst and deq_valid combinationally from registered state only, so there is no combinational path from enq_* or deq_ready to the outputs.

Reset
REQ-027 SHALL, while rst is high, immediately force count=0, both pointers=0, deq_valid=0, deq_pc=0, deq_inst=0 and enq_ready=1, regardless of clk.
REQ-028 SHALL, after reset is asserted mid-operation, have discarded all prior entries; storage contents need not be cleared.

Configuration
REQ-029 SHALL, when IFQ_PREDECODE_EN is defined, add output deq_is_cf (1 bit); it is computed at enqueue as (enq_inst[6:4]==3'b110) and stored per entry, flagging branch/jal/jalr; it is 0 when deq_valid is low and 0 during reset.
REQ-030 SHALL, when IFQ_PREDECODE_EN is undefined, omit the deq_is_cf port and its storage; all other behaviour is identical.

Verification
REQ-031 SHALL cover in-order fill: DEPTH=4, deq_ready=0, enqueue pc 0x0,0x4,0x8,0xC -> count=4, enq_ready=0; then deq_ready=1 -> deq_pc 0x0,0x4,0x8,0xC on consecutive cycles, followed by deq_inst=0 and deq_valid=0.
REQ-032 SHALL cover streaming: continuous enqueue and dequeue for 10 cycles starting from empty -> count stays 1, pointers wrap, no entry lost or duplicated.
REQ-033 SHALL cover flush: with 3 entries queued, assert flush together with enq_valid=1 -> next cycle count=0, deq_valid=0, and the enqueued instruction is absent.
REQ-034 SHALL cover rdy stall: with rdy=0 for 3 cycles while enq_valid=1, deq_ready=1 and flush=1 -> count and head unchanged.
REQ-035 SHALL cover asynchronous reset: assert rst between clock edges while count=2 -> count=0 and deq_valid=0 before the next edge.
REQ-036 SHALL cover predecode (IFQ_PREDECODE_EN defined): enqueue inst 0x0000006F (jal), then 0x00000013 (addi) -> deq_is_cf reads 1 then 0.
